// File: rtl/buff_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : buff_sched_pkg
// Brief    : Shared types and defaults for the endpoint buffer owner scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package buff_sched_pkg;

  localparam int BUF_DEPTH_DEF  = 64;
  localparam int TX_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_HOST_LOAD   = 3'd1,
    ST_TX_START    = 3'd2,
    ST_TX_WAIT_ACT = 3'd3,
    ST_TX_ACTIVE   = 3'd4,
    ST_RX_FILL     = 3'd5,
    ST_RX_HOLD     = 3'd6,
    ST_CLEAR       = 3'd7
  } sched_state_e;

  // The host owns the buffer both while loading TX data and while draining RX data.
  function automatic logic host_owns(input sched_state_e st);
    return (st == ST_HOST_LOAD) || (st == ST_RX_HOLD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module   : flex_counter
// Brief    : Up-counter with synchronous clear that saturates at rollover_val.
// Revision : 1.0 - initial release
// ============================================================================
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable && (r_count != rollover_val)) begin
      r_count <= r_count + NUM_CNT_BITS'(1);
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = (r_count == rollover_val);

endmodule
`default_nettype wire

// File: rtl/buff_owner_sched.sv
`default_nettype none
// ============================================================================
// Module   : buff_owner_sched
// Brief    : Arbitrates the shared USB endpoint buffer between host and USB RX
//            and sequences the TX load/start/transmit/clear transaction.
// Revision : 1.0 - initial release
// ============================================================================
module buff_owner_sched
  import buff_sched_pkg::*;
#(
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             host_req,
  input  logic                             host_done,
  input  logic                             host_abort,
  input  logic                             host_rd_done,
  input  logic                             rx_req,
  input  logic                             rx_done,
  input  logic                             rx_err,
  input  logic                             tx_trans_act,
  input  logic [$clog2(BUF_DEPTH+1)-1:0]   buff_occupancy,
  output logic                             buff_resv,
  output logic                             grant_host,
  output logic                             grant_rx,
  output logic                             rx_data_ready,
  output logic                             tx_packet_start,
  output logic                             buff_clear,
  output logic                             tx_timeout_err
);

  localparam int c_cnt_bits = $clog2(TX_TIMEOUT);
  localparam int c_occ_bits = $clog2(BUF_DEPTH + 1);
  localparam logic [c_cnt_bits-1:0] c_timeout_last = c_cnt_bits'(TX_TIMEOUT - 1);
  localparam logic [c_occ_bits-1:0] c_occ_max      = c_occ_bits'(BUF_DEPTH);

  sched_state_e            r_state;
  sched_state_e            w_next_state;
  logic [c_cnt_bits-1:0]   w_cnt;
  logic                    w_cnt_at_last;
  logic                    w_cnt_clear;
  logic                    w_cnt_en;
  logic                    w_timeout;

  // Counter is zeroed everywhere except while waiting for the TX transaction to begin.
  assign w_cnt_en    = (r_state == ST_TX_WAIT_ACT);
  assign w_cnt_clear = !w_cnt_en;

  flex_counter #(
    .NUM_CNT_BITS (c_cnt_bits)
  ) u_timeout_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_cnt_clear),
    .count_enable  (w_cnt_en),
    .rollover_val  (c_timeout_last),
    .count_out     (w_cnt),
    .rollover_flag (w_cnt_at_last)
  );

  assign w_timeout = (r_state == ST_TX_WAIT_ACT) && !tx_trans_act && w_cnt_at_last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        // RX cannot be NAKed mid-packet, so it beats a simultaneous host request.
        if (rx_req)        w_next_state = ST_RX_FILL;
        else if (host_req) w_next_state = ST_HOST_LOAD;
      end
      ST_HOST_LOAD: begin
        if (host_abort)     w_next_state = ST_CLEAR;
        else if (host_done) w_next_state = ST_TX_START;
      end
      ST_TX_START: w_next_state = ST_TX_WAIT_ACT;
      ST_TX_WAIT_ACT: begin
        if (tx_trans_act)   w_next_state = ST_TX_ACTIVE;
        else if (w_timeout) w_next_state = ST_CLEAR;
      end
      ST_TX_ACTIVE: begin
        if (!tx_trans_act) w_next_state = ST_CLEAR;
      end
      ST_RX_FILL: begin
        if (rx_err)       w_next_state = ST_CLEAR;
        else if (rx_done) w_next_state = ST_RX_HOLD;
      end
      ST_RX_HOLD: begin
        if (host_rd_done) w_next_state = ST_CLEAR;
      end
      ST_CLEAR: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign buff_resv       = (r_state != ST_IDLE);
  assign grant_host      = host_owns(r_state);
  assign grant_rx        = (r_state == ST_RX_FILL);
  assign rx_data_ready   = (r_state == ST_RX_HOLD);
  assign tx_packet_start = (r_state == ST_TX_START);
  assign buff_clear      = (r_state == ST_CLEAR);
  assign tx_timeout_err  = w_timeout;

  a_grant_excl: assert property (@(posedge clk) disable iff (!n_rst) !(grant_host && grant_rx));
  a_occ_range:  assert property (@(posedge clk) disable iff (!n_rst) buff_occupancy <= c_occ_max);
  a_cnt_sat:    assert property (@(posedge clk) disable iff (!n_rst) w_cnt <= c_timeout_last);

endmodule
`default_nettype wire

// File: tb/tb_buff_owner_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_buff_owner_sched
// Brief    : Directed self-checking bench for buff_owner_sched (TX_TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_buff_owner_sched;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       host_req, host_done, host_abort, host_rd_done;
  logic       rx_req, rx_done, rx_err, tx_trans_act;
  logic [6:0] buff_occupancy;
  logic       buff_resv, grant_host, grant_rx, rx_data_ready;
  logic       tx_packet_start, buff_clear, tx_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txs    = 0;
  int n_clr    = 0;
  int n_rdy    = 0;
  int n_to     = 0;

  // Expected output vectors {resv, grant_host, grant_rx, rdy, tx_start, clear, timeout}
  localparam logic [6:0] E_IDLE  = 7'b0000000;
  localparam logic [6:0] E_HLOAD = 7'b1100000;
  localparam logic [6:0] E_TXST  = 7'b1000100;
  localparam logic [6:0] E_WAIT  = 7'b1000000;
  localparam logic [6:0] E_ACT   = 7'b1000000;
  localparam logic [6:0] E_RXF   = 7'b1010000;
  localparam logic [6:0] E_RXH   = 7'b1101000;
  localparam logic [6:0] E_CLR   = 7'b1000010;
  localparam logic [6:0] E_TOUT  = 7'b1000001;

  buff_owner_sched #(
    .BUF_DEPTH  (64),
    .TX_TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .host_req        (host_req),
    .host_done       (host_done),
    .host_abort      (host_abort),
    .host_rd_done    (host_rd_done),
    .rx_req          (rx_req),
    .rx_done         (rx_done),
    .rx_err          (rx_err),
    .tx_trans_act    (tx_trans_act),
    .buff_occupancy  (buff_occupancy),
    .buff_resv       (buff_resv),
    .grant_host      (grant_host),
    .grant_rx        (grant_rx),
    .rx_data_ready   (rx_data_ready),
    .tx_packet_start (tx_packet_start),
    .buff_clear      (buff_clear),
    .tx_timeout_err  (tx_timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_packet_start) n_txs++;
    if (buff_clear)      n_clr++;
    if (rx_data_ready)   n_rdy++;
    if (tx_timeout_err)  n_to++;
  end

  function automatic logic [6:0] outs();
    return {buff_resv, grant_host, grant_rx, rx_data_ready,
            tx_packet_start, buff_clear, tx_timeout_err};
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int snap_txs, snap_clr, snap_rdy, snap_to, found;
  logic [6:0] seen;

  initial begin
    n_rst = 1'b0;
    {host_req, host_done, host_abort, host_rd_done} = '0;
    {rx_req, rx_done, rx_err, tx_trans_act} = '0;
    buff_occupancy = '0;
    repeat (3) tick();
    chk("reset_outs", int'(outs()), int'(E_IDLE));
    n_rst = 1'b1;
    tick();
    chk("idle_after_reset", int'(outs()), int'(E_IDLE));

    // Host TX flow
    snap_txs = n_txs; snap_clr = n_clr;
    host_req = 1'b1; tick(); host_req = 1'b0;
    chk("tx_host_load", int'(outs()), int'(E_HLOAD));
    for (int i = 1; i <= 10; i++) begin
      buff_occupancy = 7'(i);
      tick();
    end
    chk("tx_load_hold", int'(outs()), int'(E_HLOAD));
    host_done = 1'b1; tick(); host_done = 1'b0;
    chk("tx_start", int'(outs()), int'(E_TXST));
    tick();
    chk("tx_wait_act", int'(outs()), int'(E_WAIT));
    tx_trans_act = 1'b1; tick();
    chk("tx_active", int'(outs()), int'(E_ACT));
    repeat (39) tick();
    chk("tx_active_long", int'(outs()), int'(E_ACT));
    tx_trans_act = 1'b0; tick();
    chk("tx_clear_after_fall", int'(outs()), int'(E_CLR));
    buff_occupancy = '0;
    host_req = 1'b1; tick(); host_req = 1'b0;
    chk("tx_idle_req_in_clear_ignored", int'(outs()), int'(E_IDLE));
    chk("tx_start_pulses", n_txs - snap_txs, 1);
    chk("tx_clear_pulses", n_clr - snap_clr, 1);

    // RX beats host, then host drains
    snap_clr = n_clr;
    rx_req = 1'b1; host_req = 1'b1; tick(); rx_req = 1'b0;
    chk("rx_wins", int'(outs()), int'(E_RXF));
    tick(); host_req = 1'b0;
    chk("rx_host_req_ignored", int'(outs()), int'(E_RXF));
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    chk("rx_hold", int'(outs()), int'(E_RXH));
    tick();
    chk("rx_hold_wait", int'(outs()), int'(E_RXH));
    host_rd_done = 1'b1; tick(); host_rd_done = 1'b0;
    chk("rx_clear", int'(outs()), int'(E_CLR));
    tick();
    chk("rx_idle", int'(outs()), int'(E_IDLE));
    chk("rx_clear_pulses", n_clr - snap_clr, 1);

    // RX error beats simultaneous done
    snap_rdy = n_rdy;
    rx_req = 1'b1; tick(); rx_req = 1'b0;
    chk("rxerr_fill", int'(outs()), int'(E_RXF));
    rx_err = 1'b1; rx_done = 1'b1; tick(); rx_err = 1'b0; rx_done = 1'b0;
    chk("rxerr_clear", int'(outs()), int'(E_CLR));
    tick();
    chk("rxerr_idle", int'(outs()), int'(E_IDLE));
    chk("rxerr_no_ready", n_rdy - snap_rdy, 0);

    // TX timeout with a zero-length packet
    snap_to = n_to;
    host_req = 1'b1; tick(); host_req = 1'b0;
    host_done = 1'b1; tick(); host_done = 1'b0;
    chk("to_start", int'(outs()), int'(E_TXST));
    tick();
    found = 0;
    seen = '0;
    for (int k = 1; k <= 20; k++) begin
      if (tx_timeout_err) begin
        found = k;
        seen = outs();
        break;
      end
      tick();
    end
    chk("to_cycles_in_wait", found, 8);
    chk("to_outs", int'(seen), int'(E_TOUT));
    tick();
    chk("to_clear", int'(outs()), int'(E_CLR));
    tick();
    chk("to_idle", int'(outs()), int'(E_IDLE));
    chk("to_pulses", n_to - snap_to, 1);

    // Reset while TX_ACTIVE
    host_req = 1'b1; tick(); host_req = 1'b0;
    host_done = 1'b1; tick(); host_done = 1'b0;
    tick();
    tx_trans_act = 1'b1; tick();
    chk("rst_pre_active", int'(outs()), int'(E_ACT));
    snap_clr = n_clr;
    n_rst = 1'b0; #1;
    chk("rst_async_outs", int'(outs()), int'(E_IDLE));
    tick();
    tx_trans_act = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    chk("rst_idle", int'(outs()), int'(E_IDLE));
    chk("rst_no_clear", n_clr - snap_clr, 0);

    // Abort beats done in HOST_LOAD
    snap_txs = n_txs;
    host_req = 1'b1; tick(); host_req = 1'b0;
    host_abort = 1'b1; host_done = 1'b1; tick(); host_abort = 1'b0; host_done = 1'b0;
    chk("abort_clear", int'(outs()), int'(E_CLR));
    tick();
    chk("abort_idle", int'(outs()), int'(E_IDLE));
    chk("abort_no_tx_start", n_txs - snap_txs, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
